control_gen2: RTL and testbench
===============================

# control_gen2

Parametrised multi-cycle control unit for the simple processor datapath. It decodes the held instruction-register contents and steps a T0–T3 state machine. Each step drives the bus-mux select, register/A/G/flag load enables, the ALU op and the memory handshake. Compared with the first-generation controller, it has a configurable register count, a 3-bit opcode space fully populated (mv, mvt, add, sub, ld, st, and, cmp), immediate/register operand mode on every ALU op, and wait-state support for memory.

## Interface
- `REG_ADDR_W`, default 3: register-address width; `NUM_REGS = 2**REG_ADDR_W`.
- `INSTR_W`, default 16: instruction width.
- Derived: `SEL_W = clog2(NUM_REGS+4)`, giving 4 at defaults.
- Derived sel codes: `R0..R(NUM_REGS-1)` = register index; `G = NUM_REGS`; `IMM = NUM_REGS+1`; `IMM_HI = NUM_REGS+2`; `DIN = NUM_REGS+3`.
- Instruction fields:
  - opcode = `[INSTR_W-1 -: 3]`
  - I = `[INSTR_W-4]`
  - rX = next `REG_ADDR_W` bits
  - rY = `[REG_ADDR_W-1:0]`
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `Rest`  in  1  synchronous, active-high reset.
- `Run`  in  1  start request; sampled only in T0.
- `instruction`  in  INSTR_W  IR contents; stable from T1 to Done.
- `mem_ready`  in  1  memory access complete; may stay high.
- `IRin`, `Ain`, `Gin`, `Fin`  out  1 each  load enables for IR, A, G and flags.
- `alu_op`  out  2  ALU operation: 00 add, 01 sub, 10 and.
- `sel`  out  SEL_W  bus-mux select.
- `Rin`  out  NUM_REGS  one-hot register write enable; bit i = Ri.
- `ADDRin`, `DOUTin`, `W_D`, `mem_req`  out  1 each  memory address load, data-out load, write strobe, access request.
- `Done`  out  1  instruction complete; one cycle.
- `state`  out  2  current state: T0=00, T1=01, T2=10, T3=11.

## Operation
- Only the state register is clocked. All other outputs are combinational from `state`, `instruction`, `Run`, `mem_ready` and `Rest`.
- While `Rest`=1, all outputs are 0 and `state` is T0 at the next edge.
- Unlisted outputs are 0 in every state, including `sel` and `alu_op`; no X is ever driven.
- T0: `IRin`=`Run`. Next state is T1 if `Run` is high, else T0.
- T1:
  - mv (000): `sel` = I ? IMM : rY; `Rin[rX]`=1; `Done`=1; next T0.
  - mvt (001): `sel`=IMM_HI; `Rin[rX]`=1; `Done`=1; next T0.
  - add / sub / and / cmp (010 / 011 / 110 / 111): `sel`=rX; `Ain`=1; next T2.
  - ld / st (100 / 101): `sel`=rY; `ADDRin`=1; next T2.
- T2:
  - ALU ops: `sel` = I ? IMM : rY; `Gin`=1; `Fin`=1.
    - `alu_op`: add→00, sub and cmp→01, and→10.
    - Next T3.
  - ld: `mem_req`=1. Stay in T2 until `mem_ready`=1, then go to T3.
  - st: `sel`=rX; `DOUTin`=1; next T3.
- T3:
  - add / sub / and: `sel`=G; `Rin[rX]`=1; `Done`=1; next T0.
  - cmp: `Done`=1 only; no register write; next T0.
  - ld: `sel`=DIN; `Rin[rX]`=1; `Done`=1; next T0.
  - st: `mem_req`=1 and `W_D`=1 for every cycle spent in T3. `Done`=`mem_ready`. Next state is T0 when `mem_ready`=1, else T3.
- Once T1 is entered, `Run` is ignored and the instruction always completes.
- At most one `Rin` bit is high at any time.

## Timing
- Latencies, counted from the T0 cycle with `Run`=1 to the `Done` cycle inclusive:
  - mv, mvt: 2 cycles.
  - add, sub, and, cmp: 4 cycles.
  - ld, st: 4 + wait cycles, where wait = cycles `mem_ready` stays low in the wait state.
- `mem_ready` high on the first wait-state cycle means zero wait cycles.
- Back-to-back execution: `Done` leads to T0. If `Run` is high in that T0 cycle, the next instruction starts with no idle cycle.
- `Rest` has priority over everything. Reset asserted during any state, including a memory wait, gives `state`=T0 after that edge with all outputs 0. The interrupted instruction is abandoned; no `Done` is issued.
- `mem_ready` seen outside the T2-ld and T3-st wait states is ignored.

## Test plan
- Reset, then `Run`=1 with `instruction`=0x1405 (mv R2,#5):
  - T0: `IRin`=1.
  - T1: `sel`=9, `Rin`=0x04, `Done`=1.
  - Following cycle: T0.
- 0x4203 (add R1,R3):
  - T1: `sel`=1, `Ain`=1.
  - T2: `sel`=3, `alu_op`=00, `Gin`=`Fin`=1.
  - T3: `sel`=8, `Rin`=0x02, `Done`=1.
- 0xF00A (cmp R0,#10): T2 has `alu_op`=01 and `Fin`=1. T3 has `Done`=1 with `Rin`=0.
- 0x8806 (ld R4,[R6]) with `mem_ready` low for 3 cycles:
  - T1: `sel`=6, `ADDRin`=1.
  - `mem_req` stays high for 4 cycles in T2.
  - T3: `sel`=11, `Rin`=0x10.
  - Total of 7 cycles to `Done`.
- 0xAA02 (st R5,[R2]) with `mem_ready` held high:
  - T2: `sel`=5, `DOUTin`=1.
  - T3: `W_D`=`mem_req`=`Done`=1.
  - `Run` held low afterward: stays in T0 with `IRin`=0.
- Same ld, with `Rest` pulsed during its second wait cycle: next cycle is T0, all outputs 0, no `Done`. A subsequent mv executes normally.

Source files
------------

// File: rtl/control_gen2.sv
// Multi-cycle T0-T3 control unit: decodes the held instruction and drives the
// bus-mux select, load enables, ALU op and memory handshake for each step.
module control_gen2 #(
    parameter  int REG_ADDR_W = 3,
    parameter  int INSTR_W    = 16,
    localparam int NUM_REGS   = 2 ** REG_ADDR_W,
    localparam int SEL_W      = $clog2(NUM_REGS + 4)
) (
    input  logic                clock,
    input  logic                Rest,
    input  logic                Run,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                mem_ready,
    output logic                IRin,
    output logic                Ain,
    output logic                Gin,
    output logic                Fin,
    output logic [1:0]          alu_op,
    output logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] Rin,
    output logic                ADDRin,
    output logic                DOUTin,
    output logic                W_D,
    output logic                mem_req,
    output logic                Done,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVT = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_LD  = 3'b100,
        OP_ST  = 3'b101,
        OP_AND = 3'b110,
        OP_CMP = 3'b111
    } opcode_t;

    localparam logic [SEL_W-1:0] SEL_G      = SEL_W'(NUM_REGS);
    localparam logic [SEL_W-1:0] SEL_IMM    = SEL_W'(NUM_REGS + 1);
    localparam logic [SEL_W-1:0] SEL_IMM_HI = SEL_W'(NUM_REGS + 2);
    localparam logic [SEL_W-1:0] SEL_DIN    = SEL_W'(NUM_REGS + 3);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    state_t                  state_q, state_d;
    opcode_t                 op;
    logic                    imm_mode;
    logic [REG_ADDR_W-1:0]   rx, ry;
    logic                    rin_we;

    assign op       = opcode_t'(instruction[INSTR_W-1 -: 3]);
    assign imm_mode = instruction[INSTR_W-4];
    assign rx       = instruction[INSTR_W-5 -: REG_ADDR_W];
    assign ry       = instruction[REG_ADDR_W-1:0];

    // Bits between rX and rY belong to the immediate, which the datapath consumes.
    if (INSTR_W - 4 - REG_ADDR_W > REG_ADDR_W) begin : g_imm_bits
        logic unused_imm_bits;
        assign unused_imm_bits = ^instruction[INSTR_W-5-REG_ADDR_W : REG_ADDR_W];
    end

    function automatic logic [SEL_W-1:0] reg_sel(input logic [REG_ADDR_W-1:0] r);
        return SEL_W'(r);
    endfunction

    always_ff @(posedge clock) begin
        if (Rest) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        IRin    = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Fin     = 1'b0;
        alu_op  = ALU_ADD;
        sel     = '0;
        rin_we  = 1'b0;
        ADDRin  = 1'b0;
        DOUTin  = 1'b0;
        W_D     = 1'b0;
        mem_req = 1'b0;
        Done    = 1'b0;

        if (Rest) begin
            state_d = T0;
        end else begin
            case (state_q)
                T0: begin
                    IRin = Run;
                    if (Run) state_d = T1;
                end
                T1: begin
                    case (op)
                        OP_MV: begin
                            sel     = imm_mode ? SEL_IMM : reg_sel(ry);
                            rin_we  = 1'b1;
                            Done    = 1'b1;
                            state_d = T0;
                        end
                        OP_MVT: begin
                            sel     = SEL_IMM_HI;
                            rin_we  = 1'b1;
                            Done    = 1'b1;
                            state_d = T0;
                        end
                        OP_LD, OP_ST: begin
                            sel     = reg_sel(ry);
                            ADDRin  = 1'b1;
                            state_d = T2;
                        end
                        default: begin
                            sel     = reg_sel(rx);
                            Ain     = 1'b1;
                            state_d = T2;
                        end
                    endcase
                end
                T2: begin
                    case (op)
                        OP_LD: begin
                            mem_req = 1'b1;
                            if (mem_ready) state_d = T3;
                        end
                        OP_ST: begin
                            sel     = reg_sel(rx);
                            DOUTin  = 1'b1;
                            state_d = T3;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_CMP: begin
                            sel     = imm_mode ? SEL_IMM : reg_sel(ry);
                            Gin     = 1'b1;
                            Fin     = 1'b1;
                            alu_op  = (op == OP_ADD) ? ALU_ADD :
                                      (op == OP_AND) ? ALU_AND : ALU_SUB;
                            state_d = T3;
                        end
                        // mv/mvt never reach T2; fall back to fetch if they do.
                        default: state_d = T0;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND: begin
                            sel     = SEL_G;
                            rin_we  = 1'b1;
                            Done    = 1'b1;
                            state_d = T0;
                        end
                        OP_CMP: begin
                            Done    = 1'b1;
                            state_d = T0;
                        end
                        OP_LD: begin
                            sel     = SEL_DIN;
                            rin_we  = 1'b1;
                            Done    = 1'b1;
                            state_d = T0;
                        end
                        OP_ST: begin
                            mem_req = 1'b1;
                            W_D     = 1'b1;
                            Done    = mem_ready;
                            if (mem_ready) state_d = T0;
                        end
                        default: state_d = T0;
                    endcase
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rin
        assign Rin[gi] = rin_we && (rx == REG_ADDR_W'(gi));
    end

    assign state = Rest ? T0 : state_q;

endmodule

// File: tb/tb_control_gen2.sv
// Directed bench for control_gen2: stimulus pushes the expected per-cycle output
// bundle into a queue, a negedge monitor pops and compares it.
module tb_control_gen2;

    logic        clock = 1'b0;
    logic        Rest = 1'b1;
    logic        Run = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        IRin, Ain, Gin, Fin, ADDRin, DOUTin, W_D, mem_req, Done;
    logic [1:0]  alu_op, state;
    logic [3:0]  sel;
    logic [7:0]  Rin;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] F_IRIN = 9'h001;
    localparam logic [8:0] F_AIN  = 9'h002;
    localparam logic [8:0] F_GIN  = 9'h004;
    localparam logic [8:0] F_FIN  = 9'h008;
    localparam logic [8:0] F_ADDR = 9'h010;
    localparam logic [8:0] F_DOUT = 9'h020;
    localparam logic [8:0] F_WD   = 9'h040;
    localparam logic [8:0] F_MREQ = 9'h080;
    localparam logic [8:0] F_DONE = 9'h100;

    control_gen2 dut (
        .clock(clock), .Rest(Rest), .Run(Run), .instruction(instruction),
        .mem_ready(mem_ready), .IRin(IRin), .Ain(Ain), .Gin(Gin), .Fin(Fin),
        .alu_op(alu_op), .sel(sel), .Rin(Rin), .ADDRin(ADDRin), .DOUTin(DOUTin),
        .W_D(W_D), .mem_req(mem_req), .Done(Done), .state(state)
    );

    always #5 clock = ~clock;

    logic [24:0] exp_q[$];
    string       name_q[$];

    function automatic logic [24:0] ev(input logic [1:0] st, input logic [1:0] alu,
                                       input logic [3:0] s, input logic [7:0] rin,
                                       input logic [8:0] fl);
        return {st, alu, s, rin, fl};
    endfunction

    // Drive one cycle's inputs just after the edge and queue what the outputs must be.
    task automatic cyc(input logic rst, input logic run, input logic [15:0] ins,
                       input logic mr, input logic [24:0] e, input string nm);
        @(posedge clock);
        #1;
        Rest        = rst;
        Run         = run;
        instruction = ins;
        mem_ready   = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    logic [24:0] mon_exp, mon_act;
    string       mon_name;

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {state, alu_op, sel, Rin,
                        Done, mem_req, W_D, DOUTin, ADDRin, Fin, Gin, Ain, IRin};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got st=%0d alu=%0d sel=%0d rin=%h fl=%h, expected st=%0d alu=%0d sel=%0d rin=%h fl=%h",
                         mon_name, mon_act[24:23], mon_act[22:21], mon_act[20:17],
                         mon_act[16:9], mon_act[8:0], mon_exp[24:23], mon_exp[22:21],
                         mon_exp[20:17], mon_exp[16:9], mon_exp[8:0]);
            end else begin
                $display("ok   %s: st=%0d sel=%0d rin=%h fl=%h", mon_name,
                         mon_act[24:23], mon_act[20:17], mon_act[16:9], mon_act[8:0]);
            end
        end
    end

    initial begin
        cyc(1, 0, 16'h0000, 0, ev(0, 0, 0, 8'h00, 9'h0), "reset");
        // mv R2,#5
        cyc(0, 1, 16'h1405, 0, ev(0, 0, 0, 8'h00, F_IRIN), "mv_t0");
        cyc(0, 0, 16'h1405, 0, ev(1, 0, 9, 8'h04, F_DONE), "mv_t1");
        cyc(0, 0, 16'h1405, 0, ev(0, 0, 0, 8'h00, 9'h0), "mv_idle");
        // add R1,R3 then back-to-back cmp R0,#10
        cyc(0, 1, 16'h4203, 0, ev(0, 0, 0, 8'h00, F_IRIN), "add_t0");
        cyc(0, 0, 16'h4203, 0, ev(1, 0, 1, 8'h00, F_AIN), "add_t1");
        cyc(0, 0, 16'h4203, 0, ev(2, 0, 3, 8'h00, F_GIN | F_FIN), "add_t2");
        cyc(0, 0, 16'h4203, 0, ev(3, 0, 8, 8'h02, F_DONE), "add_t3");
        cyc(0, 1, 16'hF00A, 0, ev(0, 0, 0, 8'h00, F_IRIN), "cmp_t0");
        cyc(0, 0, 16'hF00A, 0, ev(1, 0, 0, 8'h00, F_AIN), "cmp_t1");
        cyc(0, 0, 16'hF00A, 0, ev(2, 1, 9, 8'h00, F_GIN | F_FIN), "cmp_t2");
        cyc(0, 0, 16'hF00A, 0, ev(3, 0, 0, 8'h00, F_DONE), "cmp_t3");
        // ld R4,[R6]: mem_ready in T1 is ignored, then 3 wait cycles
        cyc(0, 1, 16'h8806, 0, ev(0, 0, 0, 8'h00, F_IRIN), "ld_t0");
        cyc(0, 0, 16'h8806, 1, ev(1, 0, 6, 8'h00, F_ADDR), "ld_t1");
        cyc(0, 0, 16'h8806, 0, ev(2, 0, 0, 8'h00, F_MREQ), "ld_wait1");
        cyc(0, 0, 16'h8806, 0, ev(2, 0, 0, 8'h00, F_MREQ), "ld_wait2");
        cyc(0, 0, 16'h8806, 0, ev(2, 0, 0, 8'h00, F_MREQ), "ld_wait3");
        cyc(0, 0, 16'h8806, 1, ev(2, 0, 0, 8'h00, F_MREQ), "ld_ready");
        cyc(0, 0, 16'h8806, 0, ev(3, 0, 11, 8'h10, F_DONE), "ld_t3");
        // st R5,[R2] with mem_ready high, then idle
        cyc(0, 1, 16'hAA02, 1, ev(0, 0, 0, 8'h00, F_IRIN), "st_t0");
        cyc(0, 0, 16'hAA02, 1, ev(1, 0, 2, 8'h00, F_ADDR), "st_t1");
        cyc(0, 0, 16'hAA02, 1, ev(2, 0, 5, 8'h00, F_DOUT), "st_t2");
        cyc(0, 0, 16'hAA02, 1, ev(3, 0, 0, 8'h00, F_WD | F_MREQ | F_DONE), "st_t3");
        cyc(0, 0, 16'hAA02, 1, ev(0, 0, 0, 8'h00, 9'h0), "idle1");
        cyc(0, 0, 16'hAA02, 1, ev(0, 0, 0, 8'h00, 9'h0), "idle2");
        // st with one T3 wait cycle, back-to-back into ld
        cyc(0, 1, 16'hAA02, 0, ev(0, 0, 0, 8'h00, F_IRIN), "stw_t0");
        cyc(0, 0, 16'hAA02, 0, ev(1, 0, 2, 8'h00, F_ADDR), "stw_t1");
        cyc(0, 0, 16'hAA02, 0, ev(2, 0, 5, 8'h00, F_DOUT), "stw_t2");
        cyc(0, 0, 16'hAA02, 0, ev(3, 0, 0, 8'h00, F_WD | F_MREQ), "stw_wait");
        cyc(0, 0, 16'hAA02, 1, ev(3, 0, 0, 8'h00, F_WD | F_MREQ | F_DONE), "stw_done");
        // ld abandoned by reset in its second wait cycle
        cyc(0, 1, 16'h8806, 0, ev(0, 0, 0, 8'h00, F_IRIN), "ldr_t0");
        cyc(0, 0, 16'h8806, 0, ev(1, 0, 6, 8'h00, F_ADDR), "ldr_t1");
        cyc(0, 0, 16'h8806, 0, ev(2, 0, 0, 8'h00, F_MREQ), "ldr_wait1");
        cyc(1, 0, 16'h8806, 0, ev(0, 0, 0, 8'h00, 9'h0), "ldr_rest");
        cyc(0, 0, 16'h8806, 1, ev(0, 0, 0, 8'h00, 9'h0), "ldr_after");
        // mv R6,R3 (Run held high in T1), back-to-back mvt R5
        cyc(0, 1, 16'h0C03, 0, ev(0, 0, 0, 8'h00, F_IRIN), "mvr_t0");
        cyc(0, 1, 16'h0C03, 0, ev(1, 0, 3, 8'h40, F_DONE), "mvr_t1");
        cyc(0, 1, 16'h2A00, 0, ev(0, 0, 0, 8'h00, F_IRIN), "mvt_t0");
        cyc(0, 0, 16'h2A00, 0, ev(1, 0, 10, 8'h20, F_DONE), "mvt_t1");
        // sub R7,R2 then and R1,#4
        cyc(0, 1, 16'h6E02, 0, ev(0, 0, 0, 8'h00, F_IRIN), "sub_t0");
        cyc(0, 0, 16'h6E02, 0, ev(1, 0, 7, 8'h00, F_AIN), "sub_t1");
        cyc(0, 0, 16'h6E02, 0, ev(2, 1, 2, 8'h00, F_GIN | F_FIN), "sub_t2");
        cyc(0, 0, 16'h6E02, 0, ev(3, 0, 8, 8'h80, F_DONE), "sub_t3");
        cyc(0, 1, 16'hD204, 0, ev(0, 0, 0, 8'h00, F_IRIN), "and_t0");
        cyc(0, 0, 16'hD204, 0, ev(1, 0, 1, 8'h00, F_AIN), "and_t1");
        cyc(0, 0, 16'hD204, 0, ev(2, 2, 9, 8'h00, F_GIN | F_FIN), "and_t2");
        cyc(0, 0, 16'hD204, 0, ev(3, 0, 8, 8'h02, F_DONE), "and_t3");
        cyc(0, 0, 16'hD204, 0, ev(0, 0, 0, 8'h00, 9'h0), "final_idle");

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
